// File: rtl/pm_axi_regfile_if.sv
// pm_axi_regfile_if: AXI4-Lite channel bundle between the CPU master and the register file slave
interface pm_axi_regfile_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid;
  logic awready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic wvalid;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid;
  logic arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready;
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pm_axi_regfile.sv
// pm_axi_regfile: AXI4-Lite register file for sprite control, pellet bitmap, pellet counter and interrupts
module pm_axi_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int N_SPRITES = 4,
  parameter int N_PELLET_ROWS = 31,
  parameter int PELLET_WIDTH = 28
) (
  input  logic S_AXI_ACLK,
  input  logic S_AXI_ARESETN,
  pm_axi_regfile_if.slave s_axi,
  input  logic [16*N_SPRITES-1:0] spr_x,
  input  logic [16*N_SPRITES-1:0] spr_y,
  output logic [2*N_SPRITES-1:0] spr_dir,
  output logic [N_SPRITES-1:0] spr_mv,
  input  logic frame_start,
  input  logic eat_valid,
  input  logic [$clog2(N_PELLET_ROWS)-1:0] eat_row,
  input  logic [$clog2(PELLET_WIDTH)-1:0] eat_col,
  output logic [N_PELLET_ROWS*PELLET_WIDTH-1:0] pellets,
  output logic irq
);
  localparam int IW = C_S_AXI_ADDR_WIDTH-2;
  localparam int P0 = 4+2*N_SPRITES;
  localparam int RB = $clog2(N_PELLET_ROWS);
  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;
  if (N_PELLET_ROWS*PELLET_WIDTH >= 65536) begin : g_cnt_chk
    $error("pellet bitmap too large for a 16-bit count");
  end
  if (C_S_AXI_DATA_WIDTH != 32) begin : g_dw_chk
    $error("only 32-bit AXI data is supported");
  end
  logic up, aw_full, w_full, wr_go, wr_ok, rd_ok, eat_ok, all_clr, scan_valid, unused_ok;
  logic [IW-1:0] aw_idx, ar_idx;
  logic [31:0] w_data, wmask, rd_data;
  logic [3:0] w_strb;
  logic [2:0] irq_stat, irq_en, w1c;
  logic [2:0] ctrl_sh [N_SPRITES];
  logic [2:0] ctrl_act [N_SPRITES];
  logic [PELLET_WIDTH-1:0] pel [N_PELLET_ROWS];
  logic [PELLET_WIDTH-1:0] pel_nxt [N_PELLET_ROWS];
  logic [PELLET_WIDTH-1:0] pm;
  state_t state, state_nxt;
  logic [RB-1:0] scan_r;
  logic [15:0] acc, count, pop;
  assign s_axi.awready = up && !aw_full && !s_axi.bvalid;
  assign s_axi.wready = up && !w_full && !s_axi.bvalid;
  assign ar_idx = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign wmask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
  assign pm = wmask[PELLET_WIDTH-1:0];
  assign wr_go = aw_full && w_full && wr_ok;
  assign w1c = (wr_go && int'(aw_idx) == 1 && w_strb[0]) ? w_data[2:0] : 3'b0;
  assign eat_ok = eat_valid && int'(eat_row) < N_PELLET_ROWS && int'(eat_col) < PELLET_WIDTH;
  assign all_clr = state == PUBLISH && acc == 16'd0 && scan_valid && count != 16'd0;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0], w_data, wmask};
  always_comb begin
    wr_ok = int'(aw_idx) == 1 || int'(aw_idx) == 2 ||
            (int'(aw_idx) >= P0 && int'(aw_idx) < P0+N_PELLET_ROWS);
    for (int k = 0; k < N_SPRITES; k++)
      if (int'(aw_idx) == 5+2*k) wr_ok = 1'b1;
  end
  always_comb begin
    rd_data = '0;
    rd_ok = int'(ar_idx) < 4;
    rd_data = int'(ar_idx) == 0 ? {15'b0, scan_valid, count} :
              int'(ar_idx) == 1 ? {29'b0, irq_stat} :
              int'(ar_idx) == 2 ? {29'b0, irq_en} : 32'b0;
    for (int k = 0; k < N_SPRITES; k++) begin
      if (int'(ar_idx) == 4+2*k) begin
        rd_data = {spr_y[16*k+:16], spr_x[16*k+:16]};
        rd_ok = 1'b1;
      end
      if (int'(ar_idx) == 5+2*k) begin
        rd_data = {29'b0, ctrl_sh[k]};
        rd_ok = 1'b1;
      end
    end
    for (int r = 0; r < N_PELLET_ROWS; r++)
      if (int'(ar_idx) == P0+r) begin
        rd_data = 32'(pel[r]);
        rd_ok = 1'b1;
      end
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      up <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      s_axi.bvalid <= 1'b0;
      s_axi.bresp <= 2'b00;
      s_axi.arready <= 1'b0;
      s_axi.rvalid <= 1'b0;
      s_axi.rresp <= 2'b00;
      s_axi.rdata <= '0;
    end else begin
      up <= 1'b1;
      if (s_axi.awvalid && s_axi.awready) begin
        aw_full <= 1'b1;
        aw_idx <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (s_axi.wvalid && s_axi.wready) begin
        w_full <= 1'b1;
        w_data <= s_axi.wdata;
        w_strb <= s_axi.wstrb;
      end
      if (aw_full && w_full) begin
        aw_full <= 1'b0;
        w_full <= 1'b0;
        s_axi.bvalid <= 1'b1;
        s_axi.bresp <= wr_ok ? 2'b00 : 2'b10;
      end else if (s_axi.bvalid && s_axi.bready) s_axi.bvalid <= 1'b0;
      s_axi.arready <= s_axi.arvalid && !s_axi.rvalid && !s_axi.arready;
      if (s_axi.arvalid && s_axi.arready) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rdata <= rd_data;
        s_axi.rresp <= rd_ok ? 2'b00 : 2'b10;
      end else if (s_axi.rvalid && s_axi.rready) s_axi.rvalid <= 1'b0;
    end
  always_comb
    for (int r = 0; r < N_PELLET_ROWS; r++) begin
      pel_nxt[r] = (wr_go && int'(aw_idx) == P0+r) ? (pel[r] & ~pm) | (w_data[PELLET_WIDTH-1:0] & pm) : pel[r];
      if (eat_ok && int'(eat_row) == r) pel_nxt[r][eat_col] = 1'b0;
    end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      irq_stat <= '0;
      irq_en <= '0;
      irq <= 1'b0;
      for (int k = 0; k < N_SPRITES; k++) begin
        ctrl_sh[k] <= '0;
        ctrl_act[k] <= '0;
      end
      for (int r = 0; r < N_PELLET_ROWS; r++) pel[r] <= '1;
    end else begin
      irq_stat <= (irq_stat & ~w1c) | {all_clr, eat_ok, frame_start};
      if (wr_go && int'(aw_idx) == 2 && w_strb[0]) irq_en <= w_data[2:0];
      irq <= |(irq_stat & irq_en);
      for (int k = 0; k < N_SPRITES; k++) begin
        if (wr_go && int'(aw_idx) == 5+2*k && w_strb[0]) ctrl_sh[k] <= w_data[2:0];
        if (frame_start) ctrl_act[k] <= ctrl_sh[k];
      end
      for (int r = 0; r < N_PELLET_ROWS; r++) pel[r] <= pel_nxt[r];
    end
  always_comb begin
    pop = '0;
    for (int c = 0; c < PELLET_WIDTH; c++) pop = pop + 16'(pel[scan_r][c]);
  end
  always_comb state_nxt = (state == SCAN && int'(scan_r) != N_PELLET_ROWS-1) || state != SCAN ? SCAN : PUBLISH;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      scan_r <= '0;
      acc <= '0;
      count <= '0;
      scan_valid <= 1'b0;
    end else if (state == SCAN) begin
      acc <= acc + pop;
      scan_r <= scan_r + 1'b1;
    end else if (state == PUBLISH) begin
      count <= acc;
      scan_valid <= 1'b1;
      acc <= '0;
      scan_r <= '0;
    end
  for (genvar k = 0; k < N_SPRITES; k++) begin : g_spr
    assign spr_dir[2*k+:2] = ctrl_act[k][1:0];
    assign spr_mv[k] = ctrl_act[k][2];
  end
  for (genvar r = 0; r < N_PELLET_ROWS; r++) begin : g_pel
    assign pellets[r*PELLET_WIDTH+:PELLET_WIDTH] = pel[r];
  end
endmodule

// File: tb/tb_pm_axi_regfile.sv
// tb_pm_axi_regfile: table-driven register checks with a read-response scoreboard plus hand-timed corner sequences
module tb_pm_axi_regfile;
  localparam int NS = 4;
  localparam int NR = 31;
  localparam int PW = 28;
  localparam int P0 = 4+2*NS;
  typedef struct {int idx; logic [31:0] d; logic [1:0] r;} rvec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [16*NS-1:0] spr_x, spr_y;
  logic [2*NS-1:0] spr_dir;
  logic [NS-1:0] spr_mv;
  logic frame_start, eat_valid;
  logic [4:0] eat_row, eat_col;
  logic [NR*PW-1:0] pellets;
  logic irq;
  int checks = 0;
  int errors = 0;
  rvec_t exp_q[$];
  rvec_t tbl[10];
  rvec_t mon_e;
  always #5 clk = ~clk;
  pm_axi_regfile_if #(.ADDR_W(8), .DATA_W(32)) axi();
  pm_axi_regfile #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .N_SPRITES(NS),
    .N_PELLET_ROWS(NR), .PELLET_WIDTH(PW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .s_axi(axi),
    .spr_x(spr_x), .spr_y(spr_y), .spr_dir(spr_dir), .spr_mv(spr_mv),
    .frame_start(frame_start), .eat_valid(eat_valid), .eat_row(eat_row), .eat_col(eat_col),
    .pellets(pellets), .irq(irq)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (axi.rvalid && axi.rready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_r: got rdata %h with no read outstanding", axi.rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk($sformatf("rdata[%0d]", mon_e.idx), axi.rdata, mon_e.d);
        chk($sformatf("rresp[%0d]", mon_e.idx), 32'(axi.rresp), 32'(mon_e.r));
      end
    end
  task automatic axi_read(input int idx, input logic [31:0] ed, input logic [1:0] er);
    logic ha;
    exp_q.push_back('{idx, ed, er});
    @(negedge clk);
    axi.araddr = 8'(idx*4);
    axi.arvalid = 1'b1;
    for (int n = 0; n < 20 && axi.arvalid; n++) begin
      ha = axi.arvalid && axi.arready;
      @(posedge clk);
      #1;
      if (ha) axi.arvalid = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("ar_taken[%0d]", idx), 32'(axi.arvalid), 32'd0);
    axi.arvalid = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL r_timeout[%0d]: got no response expected one", idx);
      exp_q.delete();
    end
  endtask
  task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s, input int wd,
                           input logic [1:0] er);
    int nb;
    logic [1:0] resp;
    logic ha, hw;
    nb = 0;
    resp = 2'bxx;
    @(negedge clk);
    axi.awaddr = 8'(idx*4);
    axi.wdata = d;
    axi.wstrb = s;
    axi.awvalid = 1'b1;
    for (int n = 0; n < wd+12; n++) begin
      if (n == wd) axi.wvalid = 1'b1;
      ha = axi.awvalid && axi.awready;
      hw = axi.wvalid && axi.wready;
      if (axi.bvalid) begin
        nb++;
        resp = axi.bresp;
      end
      @(posedge clk);
      #1;
      if (ha) axi.awvalid = 1'b0;
      if (hw) axi.wvalid = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("aw_w_taken[%0d]", idx), 32'({axi.awvalid, axi.wvalid}), 32'd0);
    chk($sformatf("b_count[%0d]", idx), nb, 32'd1);
    chk($sformatf("bresp[%0d]", idx), 32'(resp), 32'(er));
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
  endtask
  task automatic start_aw_w(input int idx, input logic [31:0] d);
    @(negedge clk);
    chk("aw_w_ready", 32'({axi.awready, axi.wready}), 32'h3);
    axi.awaddr = 8'(idx*4);
    axi.wdata = d;
    axi.wstrb = 4'hf;
    axi.awvalid = 1'b1;
    axi.wvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200us");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int k = 0; k < NS; k++) begin
      spr_x[16*k+:16] = 16'(256*k+16);
      spr_y[16*k+:16] = 16'(8192+k);
    end
    frame_start = 1'b0;
    eat_valid = 1'b0;
    eat_row = '0;
    eat_col = '0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    tbl[0] = '{0, 32'h0001_0364, 2'b00};
    tbl[1] = '{1, 32'h0, 2'b00};
    tbl[2] = '{2, 32'h0, 2'b00};
    tbl[3] = '{3, 32'h0, 2'b00};
    tbl[4] = '{4, 32'h2000_0010, 2'b00};
    tbl[5] = '{10, 32'h2003_0310, 2'b00};
    tbl[6] = '{7, 32'h0, 2'b00};
    tbl[7] = '{P0, 32'h0FFF_FFFF, 2'b00};
    tbl[8] = '{P0+NR-1, 32'h0FFF_FFFF, 2'b00};
    tbl[9] = '{P0+NR, 32'h0, 2'b10};
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(axi.awready), 0);
    chk("rst_wready", 32'(axi.wready), 0);
    chk("rst_arready", 32'(axi.arready), 0);
    chk("rst_bvalid", 32'(axi.bvalid), 0);
    chk("rst_rvalid", 32'(axi.rvalid), 0);
    chk("rst_rdata", axi.rdata, 0);
    chk("rst_resps", 32'({axi.bresp, axi.rresp}), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_ctrl", 32'({spr_mv, spr_dir}), 0);
    chk("rst_pellets", 32'(&pellets), 1);
    rst_n = 1'b1;
    axi_read(P0, 32'h0FFF_FFFF, 2'b00);
    axi_read(0, 32'h0, 2'b00);
    repeat (40) @(negedge clk);
    for (int i = 0; i < 10; i++) axi_read(tbl[i].idx, tbl[i].d, tbl[i].r);
    axi_write(5, 32'h5, 4'hf, 3, 2'b00);
    repeat (3) @(negedge clk);
    chk("ctrl_before_frame", 32'({spr_mv[0], spr_dir[1:0]}), 32'h0);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("ctrl_after_frame", 32'({spr_mv[0], spr_dir[1:0]}), 32'h5);
    chk("ctrl_other_sprites", 32'({spr_mv[NS-1:1], spr_dir[2*NS-1:2]}), 32'h0);
    axi_read(5, 32'h5, 2'b00);
    start_aw_w(5, 32'h2);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("samecyc_bvalid", 32'(axi.bvalid), 1);
    chk("samecyc_active_old", 32'({spr_mv[0], spr_dir[1:0]}), 32'h5);
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    chk("samecyc_active_next", 32'({spr_mv[0], spr_dir[1:0]}), 32'h2);
    axi_write(1, 32'h7, 4'hf, 0, 2'b00);
    axi_read(1, 32'h0, 2'b00);
    start_aw_w(P0+2, 32'hFFFF_FFFF);
    eat_valid = 1'b1;
    eat_row = 5'd2;
    eat_col = 5'd5;
    @(negedge clk);
    eat_valid = 1'b0;
    chk("eat_bvalid", 32'({axi.bvalid, axi.bresp}), 32'h4);
    chk("eat_pellet_bit", 32'(pellets[2*PW+5]), 0);
    axi_read(P0+2, 32'h0FFF_FFDF, 2'b00);
    axi_read(1, 32'h2, 2'b00);
    axi_write(2, 32'h2, 4'hf, 0, 2'b00);
    chk("eat_irq", 32'(irq), 1);
    axi_write(1, 32'h2, 4'hf, 1, 2'b00);
    chk("eat_irq_cleared", 32'(irq), 0);
    @(negedge clk);
    eat_valid = 1'b1;
    eat_row = 5'd31;
    eat_col = 5'd0;
    @(negedge clk);
    eat_row = 5'd3;
    eat_col = 5'd28;
    @(negedge clk);
    eat_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("oor_irq", 32'(irq), 0);
    axi_read(1, 32'h0, 2'b00);
    axi_read(P0+3, 32'h0FFF_FFFF, 2'b00);
    axi_write(2, 32'h4, 4'hf, 0, 2'b00);
    for (int r = 0; r < NR; r++) axi_write(P0+r, 32'h0, 4'hf, 0, 2'b00);
    repeat (40) @(negedge clk);
    axi_read(0, 32'h0001_0000, 2'b00);
    axi_read(1, 32'h4, 2'b00);
    chk("allclr_irq", 32'(irq), 1);
    start_aw_w(1, 32'h4);
    @(negedge clk);
    chk("w1c_bvalid", 32'(axi.bvalid), 1);
    chk("w1c_irq_still", 32'(irq), 1);
    @(negedge clk);
    chk("w1c_irq_fell", 32'(irq), 0);
    axi_read(1, 32'h0, 2'b00);
    axi_read(63, 32'h0, 2'b10);
    axi_write(0, 32'hFFFF, 4'hf, 0, 2'b10);
    axi_read(0, 32'h0001_0000, 2'b00);
    axi_write(4, 32'h1234_5678, 4'hf, 0, 2'b10);
    axi_write(3, 32'h1, 4'hf, 0, 2'b10);
    axi_write(P0+NR, 32'h1, 4'hf, 2, 2'b10);
    axi_read(4, 32'h2000_0010, 2'b00);
    axi_write(P0, 32'h0000_AB00, 4'h2, 0, 2'b00);
    axi_read(P0, 32'h0000_AB00, 2'b00);
    @(negedge clk);
    axi.awaddr = 8'(P0*4);
    axi.awvalid = 1'b1;
    @(posedge clk);
    #1;
    axi.awvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'({axi.awready, axi.wready, axi.arready}), 0);
    chk("midrst_valid", 32'({axi.bvalid, axi.rvalid}), 0);
    chk("midrst_irq", 32'(irq), 0);
    chk("midrst_ctrl", 32'({spr_mv, spr_dir}), 0);
    chk("midrst_pellets", 32'(&pellets), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    axi_write(P0, 32'h3, 4'hf, 1, 2'b00);
    axi_read(P0, 32'h3, 2'b00);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
